// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared arbiter state encoding, read-owner tags and the
//               next-state helper for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CORE = ST_CORE,
        DMA  = ST_DMA
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    // The state always follows whoever holds the port this cycle.
    function automatic arb_state_e arb_next_state(input logic c_gnt,
                                                  input logic d_gnt);
        arb_state_e nxt;
        nxt = IDLE;
        if (c_gnt) begin
            nxt = CORE;
        end else if (d_gnt) begin
            nxt = DMA;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_cnt
// Description : Saturating count of consecutive cycles the DMA requester has
//               waited; flags starvation when the count reaches STARVE_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic d_req,
    input  logic d_gnt,
    output logic starve
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (d_gnt || !d_req) begin
            r_cnt <= '0;
        end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign starve = (r_cnt == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester (core / DMA) arbiter for a single-port data
//               memory with one-cycle read latency and DMA burst lock.
//               Define DMEM_ARB_STARVE_GUARD_EN to add the DMA anti-starvation
//               guard (arb_starve_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_lock,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);

    // r_run rises on the first clock edge after reset is released, so grants
    // are held off asynchronously but released synchronously.
    logic              r_run;
    arb_state_e        r_state;
    arb_state_e        w_next;
    logic              w_starve;
    logic              w_c_gnt;
    logic              w_d_gnt;
    logic              r_rd_pend;
    logic              r_rd_owner;
    logic [DATA_W-1:0] r_c_hold;
    logic [DATA_W-1:0] r_d_hold;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .d_req  (d_req & r_run),
        .d_gnt  (w_d_gnt),
        .starve (w_starve)
    );
`else
    assign w_starve = 1'b0;
`endif

    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (r_run) begin
            if ((r_state == DMA) && d_lock && d_req) begin
                w_d_gnt = 1'b1;
            end else if (w_starve && d_req) begin
                w_d_gnt = 1'b1;
            end else if (c_req) begin
                w_c_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = arb_next_state(w_c_gnt, w_d_gnt);
    end

    assign c_gnt   = w_c_gnt;
    assign d_gnt   = w_d_gnt;
    assign c_stall = c_req & ~w_c_gnt;

    assign wr = (w_c_gnt & c_we) | (w_d_gnt & d_we);
    assign rd = (w_c_gnt & ~c_we) | (w_d_gnt & ~d_we);

    always_comb begin
        addr    = '0;
        wr_data = '0;
        if (w_c_gnt) begin
            addr    = c_addr;
            wr_data = c_wdata;
        end else if (w_d_gnt) begin
            addr    = d_addr;
            wr_data = d_wdata;
        end
    end

    // Read data is passed straight through in its valid cycle and held after.
    assign c_rvalid = r_rd_pend & (r_rd_owner == OWN_CORE);
    assign d_rvalid = r_rd_pend & (r_rd_owner == OWN_DMA);
    assign c_rdata  = c_rvalid ? rd_data : r_c_hold;
    assign d_rdata  = d_rvalid ? rd_data : r_d_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run      <= 1'b0;
            r_state    <= IDLE;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWN_CORE;
            r_c_hold   <= '0;
            r_d_hold   <= '0;
        end else begin
            r_run      <= 1'b1;
            r_state    <= w_next;
            r_rd_pend  <= rd;
            r_rd_owner <= w_d_gnt ? OWN_DMA : OWN_CORE;
            if (c_rvalid) begin
                r_c_hold <= rd_data;
            end
            if (d_rvalid) begin
                r_d_hold <= rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed, self-checking bench for dmem_arbiter with a read
//               scoreboard and a one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit C_GUARD = 1'b1;
`else
    localparam bit C_GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_lock, d_we;
    logic [8:0]  c_addr, d_addr, addr;
    logic [31:0] c_wdata, d_wdata, wr_data, c_rdata, d_rdata, rd_data;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, wr, rd;

    typedef struct {
        logic        own;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     sb[$];
    rd_exp_t     e;
    logic [31:0] mem [0:511];
    int          n_asserts = 0;
    int          n_fail    = 0;
    bit          seen_dgnt;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (9),
        .STARVE_MAX (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_stall  (c_stall),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_req    (d_req),
        .d_lock   (d_lock),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data)
    );

    // Memory model: two preloaded words, everything else from earlier writes.
    always @(posedge clk) begin
        if (wr) mem[addr] <= wr_data;
        if (rd) begin
            if (addr == 9'h010)      rd_data <= 32'hDEADBEEF;
            else if (addr == 9'h020) rd_data <= 32'hCAFE0020;
            else                     rd_data <= mem[addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (c_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", {62'd0, c_rvalid, d_rvalid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rvalid_owner", {62'd0, c_rvalid, d_rvalid}, e.own ? 64'd1 : 64'd2);
                check("rdata", e.own ? d_rdata : c_rdata, {32'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010; c_wdata = '0;
        d_req = 1'b1; d_lock = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset window: requests present but nothing may be granted.
        repeat (2) @(posedge clk);
        sample();
        check("rst_c_gnt", c_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_wr", wr, 0);
        check("rst_rd", rd, 0);
        check("rst_c_rvalid", c_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_state", dut.r_state, IDLE);

        step();
        c_req = 1'b0; d_req = 1'b0;
        reset = 1'b1;
        step();

        // Core read of 0x010.
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010;
        sample();
        check("r22_c_gnt", c_gnt, 1);
        check("r22_rd", rd, 1);
        check("r22_wr", wr, 0);
        check("r22_addr", addr, 9'h010);
        check("r22_stall", c_stall, 0);
        sb.push_back('{OWN_CORE, 32'hDEADBEEF});
        step();
        c_req = 1'b0;
        sample();
        check("r22_c_rvalid", c_rvalid, 1);
        check("idle_addr", addr, 0);
        check("idle_rd", rd, 0);
        step();
        sample();
        check("hold_c_rvalid", c_rvalid, 0);
        check("hold_c_rdata", c_rdata, 32'hDEADBEEF);

        // Simultaneous requests: core write wins, then DMA read.
        step();
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h005; c_wdata = 32'h11111111;
        d_req = 1'b1; d_lock = 1'b0; d_we = 1'b0; d_addr = 9'h020;
        sample();
        check("r23_c_gnt", c_gnt, 1);
        check("r23_d_gnt", d_gnt, 0);
        check("r23_stall", c_stall, 0);
        check("r23_wr", wr, 1);
        check("r23_wr_data", wr_data, 32'h11111111);
        check("r23_addr", addr, 9'h005);
        step();
        c_req = 1'b0;
        sample();
        check("dma_rd_gnt", d_gnt, 1);
        check("dma_rd_addr", addr, 9'h020);
        sb.push_back('{OWN_DMA, 32'hCAFE0020});
        step();
        d_req = 1'b0;
        sample();
        check("dma_rvalid", d_rvalid, 1);

        // Locked DMA burst: entry beat, then four writes while the core waits.
        step();
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b1; d_addr = 9'h0FF; d_wdata = 32'hA5A5A5A5;
        sample();
        check("r24_entry_gnt", d_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010;
            d_addr = 9'h100 + 9'(i); d_wdata = 32'hB0000000 + i;
            sample();
            check("r24_d_gnt", d_gnt, 1);
            check("r24_c_gnt", c_gnt, 0);
            check("r24_stall", c_stall, 1);
            check("r24_addr", addr, 9'h100 + 9'(i));
            check("r24_wr_data", wr_data, 32'hB0000000 + i);
        end
        step();
        d_req = 1'b0; d_lock = 1'b0;
        sample();
        check("r24_c_gnt5", c_gnt, 1);
        check("r24_stall5", c_stall, 0);
        sb.push_back('{OWN_CORE, 32'hDEADBEEF});
        step();
        c_req = 1'b0;
        sample();

        // Core read then DMA read back-to-back; verifies earlier writes too.
        step();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
        d_req = 1'b1; d_lock = 1'b0; d_we = 1'b0; d_addr = 9'h102;
        sample();
        check("r27_c_gnt", c_gnt, 1);
        sb.push_back('{OWN_CORE, 32'h11111111});
        step();
        c_req = 1'b0;
        sample();
        check("r27_d_gnt", d_gnt, 1);
        check("r27_c_rvalid", c_rvalid, 1);
        check("r27_d_rvalid_early", d_rvalid, 0);
        sb.push_back('{OWN_DMA, 32'hB0000002});
        step();
        d_req = 1'b0;
        sample();
        check("r27_d_rvalid", d_rvalid, 1);
        check("r27_c_rvalid_late", c_rvalid, 0);

        // Both requesters hold writes for 12 cycles.
        step();
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h007; c_wdata = 32'h0;
        d_req = 1'b1; d_lock = 1'b0; d_we = 1'b1; d_addr = 9'h1FF;
        seen_dgnt = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            sample();
            check("r25_d_gnt", d_gnt, (C_GUARD && k == 9) ? 1 : 0);
            check("r25_c_gnt", c_gnt, (C_GUARD && k == 9) ? 0 : 1);
            if (d_gnt) seen_dgnt = 1'b1;
            step();
        end
        check("r25_any_d_gnt", seen_dgnt, C_GUARD);
        c_req = 1'b0; d_req = 1'b0;

        // Reset right after a granted core read kills its rvalid.
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010;
        sample();
        check("r26_c_gnt", c_gnt, 1);
        step();
        reset = 1'b0;
        sample();
        check("r26_c_rvalid", c_rvalid, 0);
        check("r26_c_gnt_rst", c_gnt, 0);
        check("r26_rd_rst", rd, 0);
        check("r26_c_rdata", c_rdata, 0);
        check("r26_state", dut.r_state, IDLE);
        step();
        reset = 1'b1;
        step();
        sample();
        check("r26_regrant", c_gnt, 1);
        sb.push_back('{OWN_CORE, 32'hDEADBEEF});
        step();
        c_req = 1'b0;
        sample();
        check("r26_rvalid_after", c_rvalid, 1);
        step();
        sample();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W SHALL exist: default 32; data width of both requesters and the memory port.
REQ-002 Parameter ADDR_W SHALL exist: default 9; word address width.
REQ-003 Parameter STARVE_MAX SHALL exist: default 8; wait-cycle limit for the DMA requester.
REQ-004 Ports SHALL be, in order:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core access request.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core access accepted this cycle.
- c_stall  out  1  c_req & ~c_gnt.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- d_req  in  1  DMA/debug access request.
- d_lock  in  1  DMA burst lock.
- d_we  in  1  DMA write (1) / read (0).
- d_addr  in  ADDR_W  DMA address.
- d_wdata  in  DATA_W  DMA write data.
- d_gnt  out  1  DMA access accepted this cycle.
- d_rvalid  out  1  DMA read data valid.
- d_rdata  out  DATA_W  DMA read data.
- wr  out  1  memory write strobe.
- rd  out  1  memory read strobe.
- addr  out  ADDR_W  memory address.
- wr_data  out  DATA_W  memory write data.
- rd_data  in  DATA_W  memory read data, valid one cycle after rd.

Function
REQ-005 At most one of c_gnt/d_gnt SHALL be high in any cycle; a grant SHALL never be issued without its req.
REQ-006 FSM states IDLE, CORE, DMA (registered); grant SHALL be combinational from the state register, requests and starvation flag.
REQ-007 Default priority: core over DMA; in IDLE or CORE, c_req wins when both request.
REQ-008 In DMA with d_lock=1 and d_req=1, d_gnt SHALL be held and the core SHALL stall, regardless of c_req.
REQ-009 Next state: granted requester's state; IDLE when no grant; DMA exits on the first cycle d_lock=0 or d_req=0.
REQ-010 In a grant cycle, wr = granted we, rd = ~granted we, and addr/wr_data SHALL mux from the granted requester; with no grant wr=rd=0, addr=0, wr_data=0.
REQ-011 Read latency: x_rvalid SHALL assert exactly one cycle after a granted read, with x_rdata = rd_data in that cycle; writes SHALL produce no rvalid.
REQ-012 x_rdata SHALL hold its last value while x_rvalid=0.
REQ-013 Back-to-back grants to alternating requesters SHALL each return rvalid to the correct owner (one-bit owner tag registered per read).

Reset
REQ-014 reset=0 SHALL asynchronously force state IDLE, starvation count 0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0.
REQ-015 During reset all grants and wr/rd SHALL be 0; a read issued in the cycle before reset SHALL produce no rvalid.
REQ-016 Release SHALL be synchronous to clk; first grant possible in the first cycle after release.

Configuration
REQ-017 Macro DMEM_ARB_STARVE_GUARD_EN SHALL enable a counter of consecutive cycles with d_req=1 and d_gnt=0, saturating at STARVE_MAX.
REQ-018 With the macro, when the count equals STARVE_MAX, d_gnt SHALL win over c_req for one cycle and the count SHALL clear on any d_gnt or d_req=0.
REQ-019 Without the macro, no counter SHALL be synthesised and strict priority (REQ-007/008) SHALL apply; DMA may starve.

Structure
REQ-020 A shared package dmem_arb_pkg SHALL hold the state enum (IDLE, CORE, DMA) and the owner-tag encoding (OWN_CORE=0, OWN_DMA=1).
REQ-021 The starvation counter SHALL be a sub-module arb_starve_cnt, instantiated only under the macro.

Verification
REQ-022 c_req read addr=0x010, mem returns 0xDEADBEEF -> c_gnt same cycle, rd=1, c_rvalid next cycle with c_rdata=0xDEADBEEF.
REQ-023 c_req and d_req simultaneous, d_lock=0 -> c_gnt=1, d_gnt=0; c_stall=0.
REQ-024 DMA granted with d_lock=1 for 4 writes to 0x100..0x103 while c_req=1 -> 4 d_gnt cycles, c_stall=1 for all 4, c_gnt on the 5th cycle.
REQ-025 Macro on, STARVE_MAX=8, c_req and d_req held high -> d_gnt on cycle 9, then c_gnt resumes; macro off -> d_gnt never.
REQ-026 Core read granted at cycle T, reset=0 at T+1 -> c_rvalid stays 0, state IDLE; after release c_req re-granted first cycle.
REQ-027 Core read then DMA read in consecutive cycles -> c_rvalid at T+1, d_rvalid at T+2, each with its own rd_data.
